// File: rtl/fetch_decode_seq.sv
// Program-counter sequencer for the DataSelect/ALU datapath: fetches 16-bit words from a
// registered ROM and decodes them over a fixed FETCH/DECODE/EXEC/WB loop.
module fetch_decode_seq #(
  parameter int PC_W = 8,
  parameter int IW   = 16,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] rom_addr,
  input  logic [IW-1:0]   rom_data,
  input  logic            zero_flag,
  output logic [1:0]      ra,
  output logic [1:0]      rb,
  output logic [1:0]      rd,
  output logic            ctl,
  output logic [DW-1:0]   romx,
  output logic [2:0]      alu_op,
  output logic            reg_we,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND  = 4'h3,
    OP_OR   = 4'h4, OP_XOR = 4'h5, OP_ADDI = 4'h6, OP_LDI = 4'h7,
    OP_JMP  = 4'h8, OP_JZ  = 4'h9, OP_HALT = 4'hF
  } opcode_t;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_PASSB = 3'd5;

  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [IW-1:0]   instr;
  logic [IW-1:0]   cur;
  logic [3:0]      cur_op;
  logic [3:0]      instr_op;
  logic [PC_W-1:0] imm_pc;

  // During DECODE the operands must already be valid, so decode straight from the ROM
  // word; afterwards the latched copy keeps them stable until the next DECODE.
  assign cur      = (state == S_DECODE) ? rom_data : instr;
  assign cur_op   = cur[15:12];
  assign instr_op = instr[15:12];
  assign imm_pc   = PC_W'(instr[7:0]);
  assign rom_addr = pc;

  // NOTE: reset is synchronous and sampled only on the clock edge, so it wins over any
  // state, including a pending WB; all sequential state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = (instr_op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      instr <= '0;
    end else begin
      if (state == S_IDLE && start) pc <= '0;
      if (state == S_DECODE) instr <= rom_data;
      if (state == S_WB) begin
        unique case (instr_op)
          OP_JMP:  pc <= imm_pc;
          OP_JZ:   pc <= zero_flag ? imm_pc : pc + PC_W'(1);
          OP_HALT: pc <= pc;
          default: pc <= pc + PC_W'(1);
        endcase
      end
    end
  end

  always_comb begin
    ra     = cur[11:10];
    rb     = cur[9:8];
    rd     = cur[11:10];
    romx   = DW'(cur[7:0]);
    ctl    = 1'b0;
    alu_op = ALU_ADD;
    unique case (cur_op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      OP_ADDI: begin ctl = 1'b1; alu_op = ALU_ADD;   end
      OP_LDI:  begin ctl = 1'b1; alu_op = ALU_PASSB; end
      default: alu_op = ALU_ADD;
    endcase
    reg_we = (state == S_WB) && (instr_op >= OP_ADD) && (instr_op <= OP_LDI);
    halted = (state == S_HALT);
  end

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Self-checking bench for fetch_decode_seq: directed vector table, multi-cycle corner
// sequences, and a randomized program run against an instruction-level reference model.
module tb_fetch_decode_seq;
  localparam int PC_W = 8;
  localparam int IW   = 16;
  localparam int DW   = 8;

  logic            clk = 1'b0;
  logic            rst, start, zero_flag;
  logic [PC_W-1:0] rom_addr;
  logic [IW-1:0]   rom_data;
  logic [1:0]      ra, rb, rd;
  logic            ctl, reg_we, halted;
  logic [DW-1:0]   romx;
  logic [2:0]      alu_op;

  fetch_decode_seq #(.PC_W(PC_W), .IW(IW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .zero_flag(zero_flag), .ra(ra), .rb(rb), .rd(rd), .ctl(ctl), .romx(romx),
    .alu_op(alu_op), .reg_we(reg_we), .halted(halted)
  );

  always #5 clk = ~clk;

  // Registered program ROM
  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] ra, rb, rd;
    logic       ctl;
    logic [7:0] romx;
    logic [2:0] alu_op;
    logic       we;
  } dec_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        zf;
    dec_t        exp;
    logic [7:0]  next_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Instruction-level meaning of a word, taken from the ISA table.
  function automatic dec_t spec_decode(input logic [15:0] w);
    dec_t d;
    int   op;
    op       = int'(w[15:12]);
    d.ra     = w[11:10];
    d.rb     = w[9:8];
    d.rd     = w[11:10];
    d.romx   = w[7:0];
    d.ctl    = (op == 6) || (op == 7);
    d.we     = (op >= 1) && (op <= 7);
    d.alu_op = 3'd0;
    if (op >= 1 && op <= 5) d.alu_op = 3'(op - 1);
    if (op == 7)            d.alu_op = 3'd5;
    return d;
  endfunction

  task automatic check_dec(input string tag, input dec_t e);
    check({tag, ".ra"},     32'(ra),     32'(e.ra));
    check({tag, ".rb"},     32'(rb),     32'(e.rb));
    check({tag, ".rd"},     32'(rd),     32'(e.rd));
    check({tag, ".ctl"},    32'(ctl),    32'(e.ctl));
    check({tag, ".romx"},   32'(romx),   32'(e.romx));
    check({tag, ".alu_op"}, 32'(alu_op), 32'(e.alu_op));
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered at the FETCH negedge; returns at the negedge after WB.
  task automatic exec_one(input string tag, input logic [7:0] exp_pc, input dec_t e,
                          input logic zf);
    check({tag, ".fetch_addr"}, 32'(rom_addr), 32'(exp_pc));
    check({tag, ".we_fetch"},   32'(reg_we),   32'd0);
    tick();
    check_dec({tag, ".dec"}, e);
    check({tag, ".we_dec"}, 32'(reg_we), 32'd0);
    tick();
    check_dec({tag, ".exec"}, e);
    check({tag, ".we_exec"}, 32'(reg_we), 32'd0);
    zero_flag = zf;
    tick();
    check({tag, ".we_wb"}, 32'(reg_we), 32'(e.we));
    tick();
    zero_flag = 1'($urandom);
    check({tag, ".we_after"}, 32'(reg_we), 32'd0);
  endtask

  vec_t vecs[12];
  int   we_cyc[$];
  dec_t z;

  initial begin
    rst = 1'b1; start = 1'b0; zero_flag = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    z = '{ra: 2'd0, rb: 2'd0, rd: 2'd0, ctl: 1'b0, romx: 8'd0, alu_op: 3'd0, we: 1'b0};

    vecs[0]  = '{"ldi",   16'h742A, 1'b0, '{2'd1, 2'd0, 2'd1, 1'b1, 8'h2A, 3'd5, 1'b1}, 8'h01};
    vecs[1]  = '{"add",   16'h1B00, 1'b0, '{2'd2, 2'd3, 2'd2, 1'b0, 8'h00, 3'd0, 1'b1}, 8'h01};
    vecs[2]  = '{"sub",   16'h2100, 1'b1, '{2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 3'd1, 1'b1}, 8'h01};
    vecs[3]  = '{"and",   16'h3E00, 1'b0, '{2'd3, 2'd2, 2'd3, 1'b0, 8'h00, 3'd2, 1'b1}, 8'h01};
    vecs[4]  = '{"or",    16'h4500, 1'b0, '{2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 3'd3, 1'b1}, 8'h01};
    vecs[5]  = '{"xor",   16'h5800, 1'b0, '{2'd2, 2'd0, 2'd2, 1'b0, 8'h00, 3'd4, 1'b1}, 8'h01};
    vecs[6]  = '{"addi",  16'h6C80, 1'b0, '{2'd3, 2'd0, 2'd3, 1'b1, 8'h80, 3'd0, 1'b1}, 8'h01};
    vecs[7]  = '{"nop",   16'h0000, 1'b1, '{2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 3'd0, 1'b0}, 8'h01};
    vecs[8]  = '{"op_b",  16'hB5A5, 1'b0, '{2'd1, 2'd1, 2'd1, 1'b0, 8'hA5, 3'd0, 1'b0}, 8'h01};
    vecs[9]  = '{"jz_t",  16'h9010, 1'b1, '{2'd0, 2'd0, 2'd0, 1'b0, 8'h10, 3'd0, 1'b0}, 8'h10};
    vecs[10] = '{"jz_nt", 16'h9010, 1'b0, '{2'd0, 2'd0, 2'd0, 1'b0, 8'h10, 3'd0, 1'b0}, 8'h01};
    vecs[11] = '{"jmp",   16'h80FF, 1'b1, '{2'd0, 2'd0, 2'd0, 1'b0, 8'hFF, 3'd0, 1'b0}, 8'hFF};

    // Reset state
    do_reset();
    check("rst.rom_addr", 32'(rom_addr), 32'd0);
    check_dec("rst", z);
    check("rst.reg_we", 32'(reg_we), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);

    // Directed single-instruction vectors
    foreach (vecs[i]) begin
      do_reset();
      rom[0] = vecs[i].instr;
      do_start();
      exec_one(vecs[i].name, 8'h00, vecs[i].exp, vecs[i].zf);
      check({vecs[i].name, ".next_addr"}, 32'(rom_addr), 32'(vecs[i].next_pc));
      check({vecs[i].name, ".halted"},    32'(halted),   32'd0);
    end

    // Back-to-back ALU ops: write-back pulses exactly 4 cycles apart
    do_reset();
    rom[0] = 16'h1B00; rom[1] = 16'h2100;
    do_start();
    we_cyc.delete();
    for (int c = 0; c < 10; c++) begin
      if (reg_we) we_cyc.push_back(c);
      if (c == 1) begin
        check("b2b.ra0", 32'(ra), 32'd2); check("b2b.rb0", 32'(rb), 32'd3);
        check("b2b.op0", 32'(alu_op), 32'd0);
      end
      if (c == 5) begin
        check("b2b.ra1", 32'(ra), 32'd0); check("b2b.rb1", 32'(rb), 32'd1);
        check("b2b.op1", 32'(alu_op), 32'd1);
      end
      tick();
    end
    check("b2b.we_count", 32'(we_cyc.size()), 32'd2);
    if (we_cyc.size() == 2) begin
      check("b2b.we_first", 32'(we_cyc[0]), 32'd3);
      check("b2b.we_gap",   32'(we_cyc[1] - we_cyc[0]), 32'd4);
    end

    // JMP to the last address, then pc wraps to zero
    do_reset();
    rom[0] = 16'h80FF; rom[255] = 16'h0000;
    do_start();
    exec_one("wrap_jmp", 8'h00, spec_decode(16'h80FF), 1'b0);
    exec_one("wrap_nop", 8'hFF, spec_decode(16'h0000), 1'b0);
    check("wrap.addr", 32'(rom_addr), 32'd0);

    // HALT: frozen, start ignored, only rst leaves
    do_reset();
    rom[0] = 16'h8005; rom[5] = 16'hF000;
    do_start();
    exec_one("h_jmp",  8'h00, spec_decode(16'h8005), 1'b0);
    exec_one("h_halt", 8'h05, spec_decode(16'hF000), 1'b0);
    for (int c = 0; c < 20; c++) begin
      start = (c % 3 == 0);
      check($sformatf("halt%0d.halted", c), 32'(halted),   32'd1);
      check($sformatf("halt%0d.we", c),     32'(reg_we),   32'd0);
      check($sformatf("halt%0d.addr", c),   32'(rom_addr), 32'd5);
      tick();
    end
    start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("halt_rst.halted", 32'(halted),   32'd0);
    check("halt_rst.addr",   32'(rom_addr), 32'd0);

    // rst during EXEC of an ADD drops the write-back
    do_reset();
    rom[0] = 16'h1B00;
    do_start();
    tick(); tick();
    check("mid.exec_ra", 32'(ra), 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid.we", 32'(reg_we), 32'd0);
    check("mid.halted", 32'(halted), 32'd0);
    check("mid.addr", 32'(rom_addr), 32'd0);
    check_dec("mid", z);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("idle%0d.we", c), 32'(reg_we), 32'd0);
      check($sformatf("idle%0d.ra", c), 32'(ra),     32'd0);
      tick();
    end

    // rst beats start on the same edge
    rst = 1'b1; start = 1'b1; tick();
    rst = 1'b0; start = 1'b0; tick(); tick();
    check("prio.ra", 32'(ra), 32'd0);
    check("prio.we", 32'(reg_we), 32'd0);

    // Randomized program against the instruction-level model
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'h7;
      rom[i] = w;
    end
    do_reset();
    do_start();
    begin
      logic [7:0] mpc;
      mpc = 8'h00;
      for (int n = 0; n < 400; n++) begin
        logic [15:0] w;
        logic        zf;
        w  = rom[mpc];
        zf = 1'($urandom);
        exec_one($sformatf("rnd%0d", n), mpc, spec_decode(w), zf);
        if (w[15:12] == 4'hF) begin
          check($sformatf("rnd%0d.halted", n), 32'(halted), 32'd1);
          do_reset();
          do_start();
          mpc = 8'h00;
        end else begin
          check($sformatf("rnd%0d.halted", n), 32'(halted), 32'd0);
          if (w[15:12] == 4'h8 || (w[15:12] == 4'h9 && zf)) mpc = w[7:0];
          else                                               mpc = mpc + 8'd1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
